// File: rtl/mem_bank_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shift-register memory bank; IDLE->ACCESS->RESP, ack 2 cycles after grant.
// Optional MEM_BANK_ARB_LOCK_EN adds lock_0/lock_1 to hold exclusive priority across accesses for atomic read-modify-write.
module mem_bank_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef MEM_BANK_ARB_LOCK_EN
    input  logic                  lock_0,
    input  logic                  lock_1,
`endif
    input  logic                  scan_enable,
    input  logic                  req_0,
    input  logic                  we_0,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    output logic                  ack_0,
    output logic [DATA_WIDTH-1:0] rdata_0,
    input  logic                  req_1,
    input  logic                  we_1,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic                  ack_1,
    output logic [DATA_WIDTH-1:0] rdata_1,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state, state_nxt;
    logic   grant_id;
    logic   last_grant;
    logic   prev_last_grant;
    logic   reg_we;
    logic   grant_vld;
    logic   grant_sel;
    logic   lock_active;
    logic   start;
    logic [DATA_WIDTH-1:0] capture;

`ifdef MEM_BANK_ARB_LOCK_EN
    logic lock_hold;
    logic lock_id;
    logic lock_owner_in;
    logic lock_grant_in;

    assign lock_owner_in = lock_id ? lock_1 : lock_0;
    assign lock_grant_in = grant_id ? lock_1 : lock_0;
    assign lock_active   = lock_hold && lock_owner_in;

    // Lock is taken during RESP of the owner's access and dropped as soon as its lock line falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_hold <= 1'b0;
            lock_id   <= 1'b0;
        end else begin
            case (state)
                RESP: begin
                    lock_hold <= lock_grant_in;
                    lock_id   <= grant_id;
                end
                IDLE: begin
                    if (lock_hold && !lock_owner_in)
                        lock_hold <= 1'b0;
                end
                default: ;
            endcase
        end
    end
`else
    logic lock_id;
    assign lock_active = 1'b0;
    assign lock_id     = 1'b0;
`endif

    always_comb begin
        grant_vld = 1'b0;
        grant_sel = 1'b0;
        if (lock_active) begin
            grant_sel = lock_id;
            grant_vld = lock_id ? req_1 : req_0;
        end else if (req_0 && req_1) begin
            grant_vld = 1'b1;
            grant_sel = ~last_grant;
        end else begin
            grant_vld = req_0 | req_1;
            grant_sel = req_1;
        end
    end

    assign start = (state == IDLE) && !scan_enable && grant_vld;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCESS;
            ACCESS:  state_nxt = scan_enable ? IDLE : RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Writes echo their own data back as the completion value.
    assign capture          = reg_we ? mem_data_in : mem_data_out;
    assign mem_write_enable = (state == ACCESS) && reg_we && !scan_enable;
    assign busy             = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            last_grant      <= 1'b1;
            prev_last_grant <= 1'b1;
            grant_id        <= 1'b0;
            reg_we          <= 1'b0;
            mem_address     <= '0;
            mem_data_in     <= '0;
            ack_0           <= 1'b0;
            ack_1           <= 1'b0;
            rdata_0         <= '0;
            rdata_1         <= '0;
        end else begin
            state <= state_nxt;
            ack_0 <= 1'b0;
            ack_1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        grant_id        <= grant_sel;
                        prev_last_grant <= last_grant;
                        last_grant      <= grant_sel;
                        reg_we          <= grant_sel ? we_1 : we_0;
                        mem_address     <= grant_sel ? addr_1 : addr_0;
                        mem_data_in     <= grant_sel ? wdata_1 : wdata_0;
                    end
                end
                ACCESS: begin
                    if (scan_enable) begin
                        // Aborted access: the same requester keeps its turn on retry.
                        last_grant <= prev_last_grant;
                    end else if (grant_id) begin
                        ack_1   <= 1'b1;
                        rdata_1 <= capture;
                    end else begin
                        ack_0   <= 1'b1;
                        rdata_0 <= capture;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Directed bench for mem_bank_arbiter with a small behavioural memory bank (address 31 = LED/button IO).
module tb_mem_bank_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          scan_enable = 1'b0;
    logic          req_0 = 1'b0, we_0 = 1'b0;
    logic [AW-1:0] addr_0 = '0;
    logic [DW-1:0] wdata_0 = '0;
    logic          ack_0;
    logic [DW-1:0] rdata_0;
    logic          req_1 = 1'b0, we_1 = 1'b0;
    logic [AW-1:0] addr_1 = '0;
    logic [DW-1:0] wdata_1 = '0;
    logic          ack_1;
    logic [DW-1:0] rdata_1;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic          mem_write_enable;
    logic [DW-1:0] mem_data_out;
    logic          busy;
`ifdef MEM_BANK_ARB_LOCK_EN
    logic          lock_0 = 1'b0;
    logic          lock_1 = 1'b0;
`endif

    logic [DW-1:0] mem [0:31] = '{default: 8'h00};
    logic [6:0]    led = 7'h00;
    logic          btn = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign mem_data_out = (mem_address == 5'd31) ? {led, btn} : mem[mem_address];

    always @(posedge clk) begin
        if (mem_write_enable) begin
            if (mem_address == 5'd31) led <= mem_data_in[7:1];
            else mem[mem_address] <= mem_data_in;
        end
    end

    mem_bank_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
`ifdef MEM_BANK_ARB_LOCK_EN
        .lock_0(lock_0), .lock_1(lock_1),
`endif
        .scan_enable(scan_enable),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .ack_0(ack_0), .rdata_0(rdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .ack_1(ack_1), .rdata_1(rdata_1),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out),
        .busy(busy)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single request by one requester; returns ack latency (-1 on timeout), rdata and write-enable cycles.
    task automatic run_access(input bit id, input bit we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, output logic [DW-1:0] rd,
                              output int lat, output int wecnt);
        @(negedge clk);
        if (id) begin req_1 = 1'b1; we_1 = we; addr_1 = a; wdata_1 = d; end
        else    begin req_0 = 1'b1; we_0 = we; addr_0 = a; wdata_0 = d; end
        lat = -1; wecnt = 0; rd = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_write_enable) wecnt++;
            if (id ? ack_1 : ack_0) begin
                lat = i;
                rd  = id ? rdata_1 : rdata_0;
                break;
            end
        end
        if (id) req_1 = 1'b0; else req_0 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (ack_0 !== 1'b0) begin miscompares++; $display("FAIL reset_ack_0: got %b expected 0", ack_0); end
        vectors++; if (ack_1 !== 1'b0) begin miscompares++; $display("FAIL reset_ack_1: got %b expected 0", ack_1); end
        vectors++; if (rdata_0 !== 8'h00) begin miscompares++; $display("FAIL reset_rdata_0: got %h expected 00", rdata_0); end
        vectors++; if (rdata_1 !== 8'h00) begin miscompares++; $display("FAIL reset_rdata_1: got %h expected 00", rdata_1); end
        vectors++; if (mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b expected 0", mem_write_enable); end
        vectors++; if (mem_address !== 5'd0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", mem_address); end
        vectors++; if (mem_data_in !== 8'h00) begin miscompares++; $display("FAIL reset_din: got %h expected 00", mem_data_in); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        logic [DW-1:0] rd;
        int lat, wecnt;
        run_access(1'b0, 1'b1, 5'd3, 8'hA5, rd, lat, wecnt);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        vectors++; if (wecnt !== 1) begin miscompares++; $display("FAIL wr_we_cycles: got %0d expected 1", wecnt); end
        vectors++; if (mem[3] !== 8'hA5) begin miscompares++; $display("FAIL wr_mem3: got %h expected a5", mem[3]); end
        run_access(1'b0, 1'b0, 5'd3, 8'h00, rd, lat, wecnt);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL rd_latency: got %0d expected 2", lat); end
        vectors++; if (wecnt !== 0) begin miscompares++; $display("FAIL rd_we_cycles: got %0d expected 0", wecnt); end
        vectors++; if (rd !== 8'hA5) begin miscompares++; $display("FAIL rd_rdata_0: got %h expected a5", rd); end
        run_access(1'b0, 1'b1, 5'd4, 8'h3C, rd, lat, wecnt);
        vectors++; if (mem[4] !== 8'h3C) begin miscompares++; $display("FAIL wr_mem4: got %h expected 3c", mem[4]); end
    endtask

    task automatic test_round_robin();
        logic [3:0] ord;
        int n, dbl, bad_rd, t0, t3;
        do_reset();
        @(negedge clk);
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 5'd3;
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 5'd4;
        ord = '0; n = 0; dbl = 0; bad_rd = 0; t0 = -1; t3 = -1;
        for (int i = 1; i <= 30 && n < 4; i++) begin
            @(negedge clk);
            if (ack_0 && ack_1) dbl++;
            if (ack_0 || ack_1) begin
                ord = {ord[2:0], ack_1};
                if (ack_0 && rdata_0 !== 8'hA5) bad_rd++;
                if (ack_1 && rdata_1 !== 8'h3C) bad_rd++;
                if (n == 0) t0 = i;
                if (n == 3) t3 = i;
                n++;
            end
        end
        req_0 = 1'b0; req_1 = 1'b0;
        vectors++; if (n !== 4) begin miscompares++; $display("FAIL rr_ack_count: got %0d expected 4", n); end
        vectors++; if (ord !== 4'b0101) begin miscompares++; $display("FAIL rr_order: got %b expected 0101", ord); end
        vectors++; if (dbl !== 0) begin miscompares++; $display("FAIL rr_double_ack: got %0d expected 0", dbl); end
        vectors++; if (bad_rd !== 0) begin miscompares++; $display("FAIL rr_rdata: got %0d bad expected 0", bad_rd); end
        vectors++; if (t0 !== 2 || t3 !== 11) begin miscompares++; $display("FAIL rr_timing: got first %0d last %0d expected 2 11", t0, t3); end
    endtask

    task automatic test_io();
        logic [DW-1:0] rd;
        int lat, wecnt;
        run_access(1'b1, 1'b1, 5'd31, 8'hFE, rd, lat, wecnt);
        vectors++; if (led !== 7'h7F) begin miscompares++; $display("FAIL io_led: got %h expected 7f", led); end
        btn = 1'b1;
        run_access(1'b1, 1'b0, 5'd31, 8'h00, rd, lat, wecnt);
        vectors++; if (rd !== 8'hFF) begin miscompares++; $display("FAIL io_rdata_1: got %h expected ff", rd); end
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL io_latency: got %0d expected 2", lat); end
        btn = 1'b0;
    endtask

    task automatic test_scan_idle();
        int bad, lat;
        @(negedge clk);
        scan_enable = 1'b1;
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 5'd7; wdata_0 = 8'h11;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy || mem_write_enable || ack_0) bad++;
        end
        scan_enable = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ack_0) begin lat = i; break; end
        end
        req_0 = 1'b0;
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL scan_idle_activity: got %0d cycles expected 0", bad); end
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL scan_idle_latency: got %0d expected 2", lat); end
        vectors++; if (mem[7] !== 8'h11) begin miscompares++; $display("FAIL scan_idle_mem7: got %h expected 11", mem[7]); end
    endtask

    task automatic test_scan_access();
        int first, lat0;
        @(negedge clk);
        req_1 = 1'b1; we_1 = 1'b1; addr_1 = 5'd5; wdata_1 = 8'h77;
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 5'd3;
        @(negedge clk);
        vectors++; if (mem_write_enable !== 1'b1) begin miscompares++; $display("FAIL sa_we_before: got %b expected 1", mem_write_enable); end
        scan_enable = 1'b1;
        #1;
        vectors++; if (mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL sa_we_gated: got %b expected 0", mem_write_enable); end
        @(negedge clk);
        vectors++; if (ack_0 !== 1'b0 || ack_1 !== 1'b0) begin miscompares++; $display("FAIL sa_no_ack: got %b%b expected 00", ack_0, ack_1); end
        vectors++; if (mem[5] !== 8'h00) begin miscompares++; $display("FAIL sa_mem5_unchanged: got %h expected 00", mem[5]); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sa_busy: got %b expected 0", busy); end
        scan_enable = 1'b0;
        first = -1; lat0 = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (first < 0 && ack_1) begin
                first = 1;
                vectors++; if (rdata_1 !== 8'h77) begin miscompares++; $display("FAIL sa_rdata_1: got %h expected 77", rdata_1); end
                vectors++; if (i !== 2) begin miscompares++; $display("FAIL sa_retry_latency: got %0d expected 2", i); end
                req_1 = 1'b0;
            end else if (first < 0 && ack_0) begin
                first = 0;
            end
            if (ack_0) begin
                lat0 = i;
                vectors++; if (rdata_0 !== 8'hA5) begin miscompares++; $display("FAIL sa_rdata_0: got %h expected a5", rdata_0); end
                break;
            end
        end
        req_0 = 1'b0; req_1 = 1'b0;
        vectors++; if (first !== 1) begin miscompares++; $display("FAIL sa_retained_priority: got requester %0d expected 1", first); end
        vectors++; if (mem[5] !== 8'h77) begin miscompares++; $display("FAIL sa_mem5_written: got %h expected 77", mem[5]); end
        vectors++; if (lat0 !== 5) begin miscompares++; $display("FAIL sa_second_ack: got %0d expected 5", lat0); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 5'd9; wdata_0 = 8'h99;
        @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rm_in_access: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy: got %b expected 0", busy); end
        vectors++; if (mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL rm_we: got %b expected 0", mem_write_enable); end
        vectors++; if (ack_0 !== 1'b0 || ack_1 !== 1'b0) begin miscompares++; $display("FAIL rm_acks: got %b%b expected 00", ack_0, ack_1); end
        vectors++; if (rdata_0 !== 8'h00 || rdata_1 !== 8'h00) begin miscompares++; $display("FAIL rm_rdata: got %h %h expected 00 00", rdata_0, rdata_1); end
        @(negedge clk);
        req_0 = 1'b0;
        vectors++; if (mem[9] !== 8'h00) begin miscompares++; $display("FAIL rm_mem9: got %h expected 00", mem[9]); end
        rst = 1'b0;
    endtask

`ifdef MEM_BANK_ARB_LOCK_EN
    task automatic test_lock();
        int n1, a0_at;
        do_reset();
        @(negedge clk);
        lock_1 = 1'b1;
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 5'd3;
        n1 = 0; a0_at = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (ack_0) begin a0_at = n1; break; end
            if (ack_1) begin
                n1++;
                if (n1 == 1) begin req_0 = 1'b1; we_0 = 1'b0; addr_0 = 5'd4; end
                if (n1 == 3) begin lock_1 = 1'b0; req_1 = 1'b0; end
            end
        end
        req_0 = 1'b0; req_1 = 1'b0; lock_1 = 1'b0;
        vectors++; if (a0_at !== 3) begin miscompares++; $display("FAIL lock_starve: got ack_0 after %0d locked accesses expected 3", a0_at); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_io();
        test_scan_idle();
        test_scan_access();
        test_reset_mid();
`ifdef MEM_BANK_ARB_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
